sqrt_core: RTL and testbench
============================

Name: sqrt_core

Overview:
- Iterative double-precision square-root datapath in the sqrt unit.
- Sits directly upstream of the sqrt output wrapper and drives its in_mantisa, in_exp and in_flags.
- Classifies the operand and computes the 53-bit root mantissa, one bit per cycle, using a restoring digit-recurrence algorithm.
- Computes the halved biased exponent.
- Uses a valid/ready handshake on both sides.

Parameters:
- M_SIZE, 53, mantissa width including the hidden bit (bit 52).
- EXP_SIZE, 11, exponent width.
- BIAS, 1023, exponent bias.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  core can accept an operand.
- in_sign  input  1  operand sign.
- in_exp  input  EXP_SIZE  biased operand exponent.
- in_mantisa  input  M_SIZE  operand mantissa: bit 52 is the hidden bit, bits 51:0 are the fraction.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_mantisa  output  M_SIZE  root mantissa with the hidden bit.
- out_exp  output  EXP_SIZE  biased root exponent.
- out_flags  output  3  classification code consumed by the output wrapper.

Behaviour:
- Reset is asynchronous and active-low (rst_n=0):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - out_mantisa, out_exp, out_flags and all internal registers are 0.
- FSM states: IDLE, CALC, DONE.
- in_ready=1 only in IDLE. An operand is accepted on a clock edge where in_valid & in_ready.
- Classification on acceptance (F = in_mantisa[51:0], E = in_exp), evaluated in priority order:
  - E=0x7FF, F≠0 (NaN): flags=011, go to DONE.
  - E=0 and F=0 (±0): flags=001, go to DONE. Negative zero is not an error.
  - in_sign=1 (negative nonzero, including -inf): flags=111, go to DONE.
  - E=0x7FF, F=0 (+inf): flags=010, go to DONE.
  - E=0, F≠0 (denormal): flags=000, go to DONE. Denormals flush to zero.
  - Otherwise: normal operand; flags=100, go to CALC.
- Special cases: out_mantisa=0 and out_exp=0. out_valid rises one cycle after acceptance.
- Normal operand, exponent:
  - out_exp = (E + BIAS) >> 1, computed at 12 bits and truncated to 11 bits.
  - This formula is correct for both exponent parities.
- Normal operand, radicand:
  - R = in_mantisa when E is odd (even unbiased exponent).
  - R = in_mantisa << 1 when E is even.
  - R is left-aligned in a 106-bit radicand register, i.e. the value is R·2^52.
- Normal operand, root (CALC):
  - Restoring integer square root of the radicand, consuming 2 radicand bits and producing 1 root bit per cycle, MSB first.
  - 53 iterations, tracked by a 6-bit counter running 52 down to 0.
  - Result Q = floor(sqrt(R·2^52)). No rounding; truncation only.
  - Q[52] is always 1 for a normal operand.
  - Partial remainder width is 55 bits. The remainder is discarded.
- Latency, normal operand:
  - Accept at edge k.
  - CALC occupies edges k+1 … k+53.
  - Move to DONE at edge k+53.
  - out_valid=1 after edge k+53.
- DONE state:
  - out_valid=1, and out_* are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid drops and the FSM returns to IDLE.
  - A new operand cannot be accepted on that same edge; there is one bubble cycle.
- out_* registers change only on transitions into DONE. Their values persist in IDLE; consumers qualify them with out_valid.
- in_valid is ignored outside IDLE. Input port values are captured at acceptance and not reread afterwards.
- rst_n asserted mid-CALC or in DONE: immediate return to the reset values. The in-flight result is lost and no out_valid pulse is produced.

Test Plan:
- sqrt(4.0): sign=0, exp=0x401, mant=53'h10000000000000 → out_valid 54 cycles after acceptance; exp=0x400, mant=53'h10000000000000, flags=100.
- sqrt(2.0): exp=0x400, mant=53'h10000000000000 → exp=0x3FF, mant=53'h16A09E667F3BCC (truncated), flags=100. Also sqrt(1.0) with exp=0x3FF → exp=0x3FF, mant=53'h10000000000000.
- Specials, each with out_valid one cycle after acceptance:
  - -1.0 (sign=1, exp=0x3FF) → flags=111.
  - +inf (exp=0x7FF, F=0) → flags=010.
  - NaN (exp=0x7FF, F=1) → flags=011.
  - -0 → flags=001.
  - Denormal (exp=0, F=5) → flags=000.
  - For every special: mant=0, exp=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. Then out_ready=1 → out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: drop rst_n at CALC iteration 20 → out_valid=0, in_ready=1 and outputs 0 immediately, asynchronously. After release, sqrt(4.0) yields the correct result.
- Back-to-back: in_valid held high with out_ready=1 and two operands (9.0, then 16.0) → results 3.0 (exp=0x400, mant=53'h18000000000000) and 4.0 (exp=0x401, mant=53'h10000000000000), in order, with one bubble between them.

Source files
------------

// File: rtl/sqrt_core.sv
// Double-precision square-root core: classifies the operand, halves the biased
// exponent and produces a truncated 53-bit root one bit per cycle.

// One restoring step: bring down two radicand bits, try subtracting 4q+1.
module sqrt_step #(
  parameter int M_SIZE = 53,
  parameter int R_W    = M_SIZE + 2
) (
  input  logic [R_W-1:0]    rem,
  input  logic [1:0]        pair,
  input  logic [M_SIZE-1:0] root,
  output logic [R_W-1:0]    rem_nxt,
  output logic [M_SIZE-1:0] root_nxt
);
  logic [R_W-1:0] rem_sh, trial;
  logic           ge;
  logic           unused_bits;

  // The remainder never exceeds 2q, so its top two bits are always clear here
  // and the root's MSB is still zero until the final step completes.
  assign rem_sh      = {rem[R_W-3:0], pair};
  assign trial       = {root[R_W-3:0], 2'b01};
  assign ge          = (rem_sh >= trial);
  assign rem_nxt     = ge ? (rem_sh - trial) : rem_sh;
  assign root_nxt    = {root[M_SIZE-2:0], ge};
  assign unused_bits = ^{rem[R_W-1:R_W-2], root[M_SIZE-1]};
endmodule

module sqrt_core #(
  parameter int M_SIZE   = 53,
  parameter int EXP_SIZE = 11,
  parameter int BIAS     = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_SIZE-1:0] in_exp,
  input  logic [M_SIZE-1:0]   in_mantisa,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M_SIZE-1:0]   out_mantisa,
  output logic [EXP_SIZE-1:0] out_exp,
  output logic [2:0]          out_flags
);
  localparam int RAD_W = 2 * M_SIZE;
  localparam int REM_W = M_SIZE + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [RAD_W-1:0]    rad;
  logic [REM_W-1:0]    rem, rem_nxt;
  logic [M_SIZE-1:0]   root, root_nxt;
  logic [5:0]          cnt;
  logic [EXP_SIZE-1:0] exp_q;

  logic                exp_max, exp_zero, frac_nz, special;
  logic [2:0]          spec_flags;
  logic [EXP_SIZE:0]   exp_sum;
  logic                unused_lsb;

  sqrt_step #(.M_SIZE(M_SIZE), .R_W(REM_W)) u_step (
    .rem      (rem),
    .pair     (rad[RAD_W-1 -: 2]),
    .root     (root),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  // (E + BIAS) >> 1 halves the unbiased exponent for either parity; the odd
  // case's missing factor of two is folded into the radicand alignment.
  assign exp_sum    = {1'b0, in_exp} + (EXP_SIZE+1)'(BIAS);
  assign unused_lsb = exp_sum[0];

  always_comb begin
    exp_max    = &in_exp;
    exp_zero   = ~|in_exp;
    frac_nz    = |in_mantisa[M_SIZE-2:0];
    special    = 1'b1;
    spec_flags = 3'b100;
    if (exp_max && frac_nz)       spec_flags = 3'b011;
    else if (exp_zero && !frac_nz) spec_flags = 3'b001;
    else if (in_sign)             spec_flags = 3'b111;
    else if (exp_max)             spec_flags = 3'b010;
    else if (exp_zero)            spec_flags = 3'b000;
    else                          special    = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_mantisa <= '0;
      out_exp     <= '0;
      out_flags   <= '0;
      rad         <= '0;
      rem         <= '0;
      root        <= '0;
      cnt         <= '0;
      exp_q       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (special) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_mantisa <= '0;
            out_exp     <= '0;
            out_flags   <= spec_flags;
          end else begin
            state <= CALC;
            cnt   <= 6'(M_SIZE - 1);
            rem   <= '0;
            root  <= '0;
            exp_q <= exp_sum[EXP_SIZE:1];
            rad   <= in_exp[0] ? {1'b0, in_mantisa, {(M_SIZE-1){1'b0}}}
                               : {in_mantisa, {M_SIZE{1'b0}}};
          end
        end
        CALC: begin
          rad  <= {rad[RAD_W-3:0], 2'b00};
          rem  <= rem_nxt;
          root <= root_nxt;
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_mantisa <= root_nxt;
            out_exp     <= exp_q;
            out_flags   <= 3'b100;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_core.sv
// Directed bench for sqrt_core: vector table plus back-pressure, reset and
// back-to-back sequences.
module tb_sqrt_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
  logic [10:0] in_exp = '0;
  logic [52:0] in_mantisa = '0;
  logic        in_ready, out_valid;
  logic [52:0] out_mantisa;
  logic [10:0] out_exp;
  logic [2:0]  out_flags;

  int n_chk = 0, n_pass = 0;

  sqrt_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mantisa(in_mantisa),
    .out_valid(out_valid), .out_ready(out_ready), .out_mantisa(out_mantisa),
    .out_exp(out_exp), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [10:0] exp;
    logic [52:0] mant;
    logic [10:0] r_exp;
    logic [52:0] r_mant;
    logic [2:0]  r_flags;
    int          lat;
  } vec_t;

  localparam logic [52:0] ONE   = 53'h10000000000000;
  localparam logic [52:0] SQRT2 = 53'h16A09E667F3BCC;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; in_sign = v.sign; in_exp = v.exp; in_mantisa = v.mant;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mantisa = '0;
  endtask

  // Returns edges counted from the accept edge (inclusive) until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_result(input vec_t v, input int lat);
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " valid"}, 64'(out_valid), 64'd1);
    chk({v.name, " mant"}, 64'(out_mantisa), 64'(v.r_mant));
    chk({v.name, " exp"}, 64'(out_exp), 64'(v.r_exp));
    chk({v.name, " flags"}, 64'(out_flags), 64'(v.r_flags));
    chk({v.name, " in_ready busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic release_out(input string name);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
    chk({name, " in_ready back"}, 64'(in_ready), 64'd1);
    @(negedge clk); out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  vec_t v4, v9, v16;
  int lat, c1, c2, got;
  logic [52:0] hold_m; logic [10:0] hold_e; logic [2:0] hold_f;
  logic stable, bubble_next, drop_valid;

  initial begin
    vecs.push_back('{"sqrt4",   0, 11'h401, ONE,         11'h400, ONE,   3'b100, 54});
    vecs.push_back('{"sqrt2",   0, 11'h400, ONE,         11'h3FF, SQRT2, 3'b100, 54});
    vecs.push_back('{"sqrt1",   0, 11'h3FF, ONE,         11'h3FF, ONE,   3'b100, 54});
    vecs.push_back('{"sqrt9",   0, 11'h402, 53'h12000000000000, 11'h400, 53'h18000000000000, 3'b100, 54});
    vecs.push_back('{"sqrtq",   0, 11'h3FD, ONE,         11'h3FE, ONE,   3'b100, 54});
    vecs.push_back('{"maxexp",  0, 11'h7FE, ONE,         11'h5FE, SQRT2, 3'b100, 54});
    vecs.push_back('{"minexp",  0, 11'h001, ONE,         11'h200, ONE,   3'b100, 54});
    vecs.push_back('{"neg1",    1, 11'h3FF, ONE,         11'h000, 53'h0, 3'b111, 1});
    vecs.push_back('{"pinf",    0, 11'h7FF, 53'h0,       11'h000, 53'h0, 3'b010, 1});
    vecs.push_back('{"ninf",    1, 11'h7FF, 53'h0,       11'h000, 53'h0, 3'b111, 1});
    vecs.push_back('{"nan",     0, 11'h7FF, 53'h1,       11'h000, 53'h0, 3'b011, 1});
    vecs.push_back('{"negnan",  1, 11'h7FF, 53'h1,       11'h000, 53'h0, 3'b011, 1});
    vecs.push_back('{"negzero", 1, 11'h000, 53'h0,       11'h000, 53'h0, 3'b001, 1});
    vecs.push_back('{"denorm",  0, 11'h000, 53'h5,       11'h000, 53'h0, 3'b000, 1});
    v4  = vecs[0];
    v9  = vecs[3];
    v16 = '{"sqrt16", 0, 11'h403, ONE, 11'h401, ONE, 3'b100, 54};

    #12;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset outputs", 64'({out_mantisa, out_exp, out_flags}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      wait_valid(lat);
      check_result(vecs[i], lat);
      release_out(vecs[i].name);
    end

    // Back-pressure: outputs frozen while out_ready stays low.
    drive(v4);
    wait_valid(lat);
    check_result(v4, lat);
    hold_m = out_mantisa; hold_e = out_exp; hold_f = out_flags; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_mantisa !== hold_m || out_exp !== hold_e ||
          out_flags !== hold_f) stable = 1'b0;
    end
    chk("backpressure stable", 64'(stable), 64'd1);
    release_out("backpressure");

    // Asynchronous reset during CALC iteration 20.
    drive(v4);
    repeat (19) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset outputs", 64'({out_mantisa, out_exp, out_flags}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(v4);
    wait_valid(lat);
    check_result(v4, lat);
    release_out("postreset");

    // Back-to-back with in_valid held high and out_ready=1.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_sign = v9.sign; in_exp = v9.exp; in_mantisa = v9.mant;
    @(posedge clk); #1;
    in_exp = v16.exp; in_mantisa = v16.mant;
    got = 0; c1 = 0; c2 = 0; bubble_next = 1'b0; drop_valid = 1'b0;
    for (int c = 1; c < 300 && got < 2; c++) begin
      @(posedge clk); #1;
      if (drop_valid) begin in_valid = 1'b0; drop_valid = 1'b0; end
      if (out_valid) begin
        if (got == 0) begin
          c1 = c;
          chk("b2b first mant", 64'(out_mantisa), 64'(v9.r_mant));
          chk("b2b first exp", 64'(out_exp), 64'(v9.r_exp));
          bubble_next = 1'b1;
        end else begin
          c2 = c;
          chk("b2b second mant", 64'(out_mantisa), 64'(v16.r_mant));
          chk("b2b second exp", 64'(out_exp), 64'(v16.r_exp));
          chk("b2b second flags", 64'(out_flags), 64'(v16.r_flags));
        end
        got++;
      end else if (bubble_next) begin
        chk("b2b bubble in_ready", 64'(in_ready), 64'd1);
        bubble_next = 1'b0;
        drop_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("b2b results seen", 64'(got), 64'd2);
    chk("b2b spacing", 64'(c2 - c1), 64'd55);
    @(negedge clk); out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
